adc_ad4003_mc_reader: RTL and testbench

ADC_AD4003_MC_READER -- requirements
Module: adc_ad4003_mc_reader

---
 rtl/adc_ad4003_pkg.sv | 27 ++
 rtl/adc_ad4003_ch_sr.sv | 35 +++
 rtl/adc_ad4003_mc_reader.sv | 129 ++++++++++++
 tb/tb_adc_ad4003_mc_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ad4003_pkg.sv
// Shared FSM encoding, default timing constants and helpers for the
// multi-channel AD4003 reader.
package adc_ad4003_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  localparam int unsigned DEF_N_CHANNELS      = 4;
  localparam int unsigned DEF_ADC_DATA_WIDTH  = 18;
  localparam int unsigned DEF_OUT_WIDTH       = 32;
  localparam int unsigned DEF_CNV_HIGH_CYCLES = 4;
  localparam int unsigned DEF_TCONV_CYCLES    = 24;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_ad4003_ch_sr.sv
// One SDO channel: MSB-first shift register and sign-extended output word.
module adc_ad4003_ch_sr
  import adc_ad4003_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = DEF_ADC_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH      = DEF_OUT_WIDTH
) (
  input  logic                  adc_read_clk,
  input  logic                  rstn,
  input  logic                  shift_en,
  input  logic                  latch_en,
  input  logic                  sdo,
  output logic [OUT_WIDTH-1:0]  data
);

  logic [ADC_DATA_WIDTH-1:0] sr;
  logic [ADC_DATA_WIDTH-1:0] sr_nxt;

  // The output word is loaded from the post-shift value so that the final
  // SDO bit lands in the same edge that enters LATCH.
  always_comb begin
    sr_nxt = (sr << 1) | ADC_DATA_WIDTH'(sdo);
  end

  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      sr   <= '0;
      data <= '0;
    end else begin
      if (shift_en) sr <= sr_nxt;
      if (latch_en) data <= OUT_WIDTH'($signed(sr_nxt));
    end
  end

endmodule

// File: rtl/adc_ad4003_mc_reader.sv
// Multi-channel AD4003 reader: CNV pulse, conversion wait, gated-SCK read of
// N parallel SDO lines, sign-extended latch with a one-cycle valid strobe.
module adc_ad4003_mc_reader
  import adc_ad4003_pkg::*;
#(
  parameter int unsigned N_CHANNELS      = DEF_N_CHANNELS,
  parameter int unsigned ADC_DATA_WIDTH  = DEF_ADC_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH       = DEF_OUT_WIDTH,
  parameter int unsigned CNV_HIGH_CYCLES = DEF_CNV_HIGH_CYCLES,
  parameter int unsigned TCONV_CYCLES    = DEF_TCONV_CYCLES,
  parameter int          TCQ             = 1
) (
  input  logic                            adc_read_clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            free_run,
  input  logic                            overrun_clr,
  input  logic [N_CHANNELS-1:0]           adc_sdo,
  output logic                            adc_cnv,
  output logic                            adc_sck_en,
  output logic [N_CHANNELS*OUT_WIDTH-1:0] adc_data,
  output logic                            data_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int unsigned CNT_MAX = max3(CNV_HIGH_CYCLES, TCONV_CYCLES, ADC_DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // TCQ stays on the parameter list so existing instantiations still bind;
  // the registers themselves carry no delay.
  if (OUT_WIDTH < ADC_DATA_WIDTH || CNV_HIGH_CYCLES < 1 || TCONV_CYCLES < 1 ||
      ADC_DATA_WIDTH < 1 || N_CHANNELS < 1 || TCQ < 0) begin : g_bad_params
    $error("adc_ad4003_mc_reader: illegal parameter combination");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             shift_en;
  logic             latch_en;

  assign shift_en = (state == ST_READ);
  assign latch_en = (state == ST_READ) && (cnt == CNT_W'(ADC_DATA_WIDTH - 1));

  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      adc_cnv    <= 1'b0;
      adc_sck_en <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // Set wins over clear so a collision never loses an overrun event.
      if (start && (state != ST_IDLE))
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start || free_run) begin
            state   <= ST_CONV;
            cnt     <= '0;
            adc_cnv <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_CONV: begin
          if (cnt == CNT_W'(CNV_HIGH_CYCLES - 1)) begin
            state   <= ST_WAIT;
            cnt     <= '0;
            adc_cnv <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(TCONV_CYCLES - 1)) begin
            state      <= ST_READ;
            cnt        <= '0;
            adc_sck_en <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (cnt == CNT_W'(ADC_DATA_WIDTH - 1)) begin
            state      <= ST_LATCH;
            cnt        <= '0;
            adc_sck_en <= 1'b0;
            data_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          adc_cnv    <= 1'b0;
          adc_sck_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    adc_ad4003_ch_sr #(
      .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
      .OUT_WIDTH      (OUT_WIDTH)
    ) u_ch_sr (
      .adc_read_clk (adc_read_clk),
      .rstn         (rstn),
      .shift_en     (shift_en),
      .latch_en     (latch_en),
      .sdo          (adc_sdo[g]),
      .data         (adc_data[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_adc_ad4003_mc_reader.sv
// Randomised self-checking bench for adc_ad4003_mc_reader at default parameters.
module tb_adc_ad4003_mc_reader;

  localparam int unsigned NCH = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             free_run;
  logic             overrun_clr;
  logic [NCH-1:0]   sdo = '0;
  logic             adc_cnv;
  logic             adc_sck_en;
  logic [NCH*32-1:0] adc_data;
  logic             data_valid;
  logic             busy;
  logic             overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  logic [17:0]  words [NCH];
  int unsigned  bit_idx = 0;

  adc_ad4003_mc_reader #(
    .N_CHANNELS      (NCH),
    .ADC_DATA_WIDTH  (18),
    .OUT_WIDTH       (32),
    .CNV_HIGH_CYCLES (4),
    .TCONV_CYCLES    (24),
    .TCQ             (1)
  ) dut (
    .adc_read_clk (clk),
    .rstn         (rstn),
    .start        (start),
    .free_run     (free_run),
    .overrun_clr  (overrun_clr),
    .adc_sdo      (sdo),
    .adc_cnv      (adc_cnv),
    .adc_sck_en   (adc_sck_en),
    .adc_data     (adc_data),
    .data_valid   (data_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: presents the next MSB-first bit of each channel's word during
  // every cycle in which the SCK gate is open.
  always @(negedge clk) begin
    if (!rstn || !adc_sck_en) begin
      bit_idx = 0;
    end else begin
      for (int c = 0; c < NCH; c++) sdo[c] = words[c][17 - bit_idx];
      bit_idx++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext18(input logic [17:0] w);
    int v;
    v = int'(w);
    if (v >= 131072) v = v - 262144;
    return 32'(v);
  endfunction

  // One start-triggered conversion; optionally pokes start (and overrun_clr)
  // poke_at cycles into the busy window.
  task automatic run_one(input string tag, input int unsigned poke_at, input logic poke_clr);
    int unsigned t0, lat, n_cnv, n_sck, n_busy, n_dv;
    logic [NCH*32-1:0] snap;
    lat = 0; n_cnv = 0; n_sck = 0; n_busy = 0; n_dv = 0; snap = '0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (poke_at != 0 && i == poke_at + 1)
        check({tag, "_overrun_set"}, 128'(overrun), 128'(1));
      if (busy) n_busy++;
      if (adc_cnv) n_cnv++;
      if (adc_sck_en) n_sck++;
      if (data_valid) begin
        n_dv++;
        lat = cyc - t0;
        snap = adc_data;
      end
      if (!busy) break;
      if (poke_at != 0 && i == poke_at) begin
        start = 1'b1;
        overrun_clr = poke_clr;
      end else begin
        start = 1'b0;
        overrun_clr = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    overrun_clr = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(47));
    check({tag, "_dv_count"}, 128'(n_dv), 128'(1));
    check({tag, "_cnv_cycles"}, 128'(n_cnv), 128'(4));
    check({tag, "_sck_cycles"}, 128'(n_sck), 128'(18));
    check({tag, "_busy_cycles"}, 128'(n_busy), 128'(47));
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_ch%0d", tag, c), 128'(snap[c*32 +: 32]), 128'(sext18(words[c])));
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_hold_ch%0d", tag, c), 128'(adc_data[c*32 +: 32]), 128'(sext18(words[c])));
  endtask

  initial begin
    int unsigned cnt_busy, cnt_dv, n_fr;
    int unsigned t_dv [3];

    rstn = 1'b0; start = 1'b0; free_run = 1'b0; overrun_clr = 1'b0;
    for (int c = 0; c < NCH; c++) words[c] = '0;
    repeat (3) @(negedge clk);
    check("rst_cnv", 128'(adc_cnv), 128'(0));
    check("rst_sck", 128'(adc_sck_en), 128'(0));
    check("rst_dv", 128'(data_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_overrun", 128'(overrun), 128'(0));
    check("rst_data", 128'(adc_data), 128'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Full-scale boundary words on ch0/ch1.
    words[0] = 18'h1FFFF;
    words[1] = 18'h20000;
    words[2] = 18'h3FFFF;
    words[3] = 18'h00001;
    run_one("dir", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
      run_one($sformatf("rnd%0d", r), 0, 1'b0);
    end

    check("pre_ovr", 128'(overrun), 128'(0));
    for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
    run_one("ovr", 9, 1'b0);
    cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cnt_busy++;
      @(negedge clk);
    end
    check("ovr_no_extra_conv", 128'(cnt_busy), 128'(0));
    check("ovr_sticky", 128'(overrun), 128'(1));
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", 128'(overrun), 128'(0));

    for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
    run_one("sim", 5, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("sim_cleared", 128'(overrun), 128'(0));

    // Free-running: three conversions, then drop free_run in the last LATCH.
    for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
    free_run = 1'b1;
    n_fr = 0;
    for (int i = 0; i < 400 && n_fr < 3; i++) begin
      @(negedge clk);
      if (data_valid) begin
        t_dv[n_fr] = cyc;
        for (int c = 0; c < NCH; c++)
          check($sformatf("fr%0d_ch%0d", n_fr, c), 128'(adc_data[c*32 +: 32]),
                128'(sext18(words[c])));
        for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
        n_fr++;
        if (n_fr == 3) free_run = 1'b0;
      end
    end
    free_run = 1'b0;
    check("fr_count", 128'(n_fr), 128'(3));
    if (n_fr == 3) begin
      check("fr_period01", 128'(t_dv[1] - t_dv[0]), 128'(48));
      check("fr_period12", 128'(t_dv[2] - t_dv[1]), 128'(48));
    end
    @(negedge clk);
    cnt_busy = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) cnt_busy++;
      @(negedge clk);
    end
    check("fr_stops", 128'(cnt_busy), 128'(0));
    check("fr_overrun", 128'(overrun), 128'(0));

    // Reset in the middle of READ.
    words[0] = 18'h2AAAA; words[1] = 18'h15555; words[2] = 18'h3C3C3; words[3] = 18'h0F0F0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !adc_sck_en; i++) @(negedge clk);
    check("mid_read_reached", 128'(adc_sck_en), 128'(1));
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_sck", 128'(adc_sck_en), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_cnv", 128'(adc_cnv), 128'(0));
    check("mid_rst_data", 128'(adc_data), 128'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cnt_busy = 0; cnt_dv = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) cnt_busy++;
      if (data_valid) cnt_dv++;
    end
    check("post_rst_idle", 128'(cnt_busy), 128'(0));
    check("post_rst_no_dv", 128'(cnt_dv), 128'(0));

    for (int c = 0; c < NCH; c++) words[c] = 18'($urandom);
    run_one("post_rst", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
